flu_issue_scheduler: RTL and testbench
======================================

# flu_issue_scheduler

Issue scheduler for the fixed-latency unit (FLU) cluster in the execute stage. The FLU comprises ALU, branch unit, CSR buffer and multiplier/divider, and all four share one writeback port into the scoreboard. This block accepts one issue candidate per cycle and decides whether it may issue without colliding on that port. It tracks multiplier writeback slots, divider occupancy and the single-entry CSR buffer, and drives the per-unit valid strobes into the execute stage.

## Interface
Parameters:
- MulLat, 1: multiplier latency in cycles, issue to result. Legal range 1..4.
- TransIdBits, 3: scoreboard transaction ID width.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- flush_i, in, 1: pipeline flush.
- issue_valid_i, in, 1: candidate instruction present.
- issue_fu_i, in, 3: FLU class of the candidate, type flu_class_e.
- issue_trans_id_i, in, TransIdBits: scoreboard ID of the candidate.
- issue_ready_o, out, 1: candidate may issue this cycle.
- alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, out, 1 each: unit strobes. mult_valid_o covers both MUL and DIV.
- csr_commit_i, in, 1: the buffered CSR instruction commits.
- div_done_i, in, 1: divider result is on the writeback port this cycle.
- exp_wb_valid_o, out, 1: a multiplier result is due on the writeback port this cycle.
- exp_wb_trans_id_o, out, TransIdBits: ID of that expected result.
- slot_stall_o, out, 1: candidate was stalled only because of a writeback-slot conflict.

## Operation
- Grant condition: grant = issue_valid_i & issue_ready_o. Exactly one unit strobe is asserted on a grant, selected by class. All strobes are 0 when there is no grant.
- issue_ready_o is combinational from registered state, issue_fu_i and div_done_i. It does not depend on issue_valid_i.
- issue_ready_o = 0 in any of these cases: flush_i=1, csr_pending=1, div_busy=1, or issue_fu_i is an illegal encoding (5..7).
- Reservation vector resv[MulLat:0] with parallel tid[MulLat:0]. Bit k set means the writeback slot k cycles ahead is taken. Every cycle the vector shifts down one position (resv[k] <= resv[k+1]) and the top bit fills with 0 unless a MUL is granted.
- ALU, BRANCH and CSR are ready when resv[0]=0 and div_done_i=0.
- MUL is ready when resv[MulLat-1]=0 after the shift. Equivalently, slot MulLat is free; this is checked against resv[MulLat]. A MUL grant sets resv[MulLat] and tid[MulLat] <= issue_trans_id_i.
- DIV is ready when all of resv is clear. A DIV grant sets div_busy. div_done_i clears div_busy. The divider owns the port in its done cycle.
- A CSR grant sets csr_pending. csr_commit_i clears it, taking effect next cycle; a same-cycle commit does not raise ready.
- exp_wb_valid_o = resv[0] and exp_wb_trans_id_o = tid[0]. Both are registered.
- slot_stall_o = issue_valid_i & ~issue_ready_o, when the only blocking reason is a resv or div_done_i conflict.
- On flush_i, resv, tid, div_busy and csr_pending all clear on the next edge. Grants are suppressed during the flush cycle.
- Simultaneous flush_i and csr_commit_i: the flush wins, and the end state is identical either way.
- If div_done_i arrives while div_busy=0, it is ignored apart from blocking slot 0 that cycle.

## Timing
- Reset values: every registered output is 0, and resv, tid, div_busy and csr_pending are 0. After reset issue_ready_o=1 for every legal class.
- Grant-to-strobe latency is 0 cycles; strobes are combinational.
- With MulLat=1:
  - MUL granted at cycle t gives exp_wb_valid_o=1 at t+1.
  - An ALU candidate at t+1 is stalled; the same candidate at t+2 is granted.
- Back-to-back MULs issue every cycle, because each targets a distinct slot.
- A DIV blocks all issue from the cycle after its grant through the cycle in which div_done_i is seen. Issue resumes the following cycle.
- Reset mid-operation clears all state asynchronously. No writeback expectation survives the reset.

## Structure
- The flu_class_e enum (ALU=0, BRANCH=1, CSR=2, MUL=3, DIV=4) and the MulLat range bound belong in ariane_pkg.
- Natural sub-module: flu_wb_slot_tracker, which holds the reservation and ID shift register with its set, shift and clear logic. The top-level block keeps the ready/strobe logic and the div and CSR flags.

## Test plan
- Reset, then ALU candidate with issue_valid_i=1 -> issue_ready_o=1, alu_valid_o=1 in the same cycle, all other strobes 0.
- MulLat=1: MUL with trans_id 5 at t, ALU at t+1 and t+2 -> exp_wb_valid_o=1 and exp_wb_trans_id_o=5 at t+1; ALU stalled at t+1 with slot_stall_o=1; ALU granted at t+2.
- CSR at t, CSR and ALU candidates at t+1..t+3, csr_commit_i at t+3 -> ready=0 for t+1..t+3; granted at t+4.
- DIV at t, div_done_i at t+10 -> ready=0 for t+1..t+10, slot 0 blocked at t+10, MUL granted at t+11.
- MulLat=2: MULs with IDs 1, 2, 3 on consecutive cycles, flush_i on the third cycle -> third not granted; exp_wb_valid_o=0 from the cycle after the flush onward; resv is clear.
- Illegal issue_fu_i=6 with valid held high -> issue_ready_o=0, no strobes, slot_stall_o=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared FLU class encoding and multiplier latency bound
package ariane_pkg;

    localparam int unsigned MAX_MUL_LAT = 4;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        BRANCH = 3'd1,
        CSR    = 3'd2,
        MUL    = 3'd3,
        DIV    = 3'd4
    } flu_class_e;

endpackage

// File: rtl/flu_wb_slot_tracker.sv
// rtl/flu_wb_slot_tracker.sv - writeback slot reservation and trans-id shift register
module flu_wb_slot_tracker #(
    parameter int unsigned MulLat      = 1,
    parameter int unsigned TransIdBits = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   set_i,
    input  logic [TransIdBits-1:0] set_trans_id_i,
    output logic [MulLat:0]        resv_o,
    output logic                   wb_valid_o,
    output logic [TransIdBits-1:0] wb_trans_id_o
);

    logic [MulLat:0]                   resv_q, resv_d;
    logic [MulLat:0][TransIdBits-1:0]  tid_q, tid_d;

    // The storage is indexed relative to the next cycle: a MUL granted now
    // claims slot MulLat, which after this edge sits at index MulLat-1.
    assign resv_d = clear_i ? '0
                  : ({1'b0, resv_q[MulLat:1]} | ({{MulLat{1'b0}}, set_i} << (MulLat - 1)));

    for (genvar k = 0; k <= MulLat; k++) begin : g_tid
        if (k == MulLat) begin : g_top
            assign tid_d[k] = '0;
        end else if (k == MulLat - 1) begin : g_set
            assign tid_d[k] = clear_i ? '0 : (set_i ? set_trans_id_i : tid_q[k+1]);
        end else begin : g_shift
            assign tid_d[k] = clear_i ? '0 : tid_q[k+1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resv_q <= '0;
            tid_q  <= '0;
        end else begin
            resv_q <= resv_d;
            tid_q  <= tid_d;
        end
    end

    assign resv_o        = resv_q;
    assign wb_valid_o    = resv_q[0];
    assign wb_trans_id_o = tid_q[0];

endmodule

// File: rtl/flu_issue_scheduler.sv
// rtl/flu_issue_scheduler.sv - FLU issue gating against the shared writeback port
module flu_issue_scheduler
    import ariane_pkg::*;
#(
    parameter int unsigned MulLat      = 1,
    parameter int unsigned TransIdBits = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    input  flu_class_e             issue_fu_i,
    input  logic [TransIdBits-1:0] issue_trans_id_i,
    output logic                   issue_ready_o,
    output logic                   alu_valid_o,
    output logic                   branch_valid_o,
    output logic                   csr_valid_o,
    output logic                   mult_valid_o,
    input  logic                   csr_commit_i,
    input  logic                   div_done_i,
    output logic                   exp_wb_valid_o,
    output logic [TransIdBits-1:0] exp_wb_trans_id_o,
    output logic                   slot_stall_o
);

    if (MulLat < 1 || MulLat > MAX_MUL_LAT) begin : g_bad_mul_lat
        $error("flu_issue_scheduler: MulLat out of range");
    end

    logic            csr_pending_q, div_busy_q;
    logic [MulLat:0] resv;
    logic            legal, slot_free, base_ok, grant;

    always_comb begin
        legal     = 1'b1;
        slot_free = 1'b0;
        case (issue_fu_i)
            ALU, BRANCH, CSR: slot_free = ~resv[0] & ~div_done_i;
            MUL:              slot_free = ~resv[MulLat];
            DIV:              slot_free = ~|resv;
            default:          legal     = 1'b0;
        endcase
    end

    assign base_ok       = ~flush_i & ~csr_pending_q & ~div_busy_q;
    assign issue_ready_o = base_ok & legal & slot_free;
    assign grant         = issue_valid_i & issue_ready_o;
    // Stall is attributed to the port only when nothing else would have blocked.
    assign slot_stall_o  = issue_valid_i & base_ok & legal & ~slot_free;

    assign alu_valid_o    = grant & (issue_fu_i == ALU);
    assign branch_valid_o = grant & (issue_fu_i == BRANCH);
    assign csr_valid_o    = grant & (issue_fu_i == CSR);
    assign mult_valid_o   = grant & ((issue_fu_i == MUL) | (issue_fu_i == DIV));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_pending_q <= 1'b0;
            div_busy_q    <= 1'b0;
        end else if (flush_i) begin
            csr_pending_q <= 1'b0;
            div_busy_q    <= 1'b0;
        end else begin
            if (grant && issue_fu_i == CSR) csr_pending_q <= 1'b1;
            else if (csr_commit_i)          csr_pending_q <= 1'b0;
            if (grant && issue_fu_i == DIV) div_busy_q <= 1'b1;
            else if (div_done_i)            div_busy_q <= 1'b0;
        end
    end

    flu_wb_slot_tracker #(
        .MulLat      (MulLat),
        .TransIdBits (TransIdBits)
    ) u_slot_tracker (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (flush_i),
        .set_i          (grant && issue_fu_i == MUL),
        .set_trans_id_i (issue_trans_id_i),
        .resv_o         (resv),
        .wb_valid_o     (exp_wb_valid_o),
        .wb_trans_id_o  (exp_wb_trans_id_o)
    );

endmodule

// File: tb/tb_flu_issue_scheduler.sv
// tb/tb_flu_issue_scheduler.sv - directed bench for flu_issue_scheduler (MulLat 1 and 2)
module tb_flu_issue_scheduler;
    import ariane_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush, valid, commit, done;
    flu_class_e fu;
    logic [2:0] tid;

    logic       rdy, alu_v, br_v, csr_v, mul_v, wb_v, stall;
    logic [2:0] wb_id;
    logic       rdy2, alu_v2, br_v2, csr_v2, mul_v2, wb_v2, stall2;
    logic [2:0] wb_id2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    flu_issue_scheduler #(.MulLat(1), .TransIdBits(3)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .issue_valid_i(valid),
        .issue_fu_i(fu), .issue_trans_id_i(tid), .issue_ready_o(rdy),
        .alu_valid_o(alu_v), .branch_valid_o(br_v), .csr_valid_o(csr_v),
        .mult_valid_o(mul_v), .csr_commit_i(commit), .div_done_i(done),
        .exp_wb_valid_o(wb_v), .exp_wb_trans_id_o(wb_id), .slot_stall_o(stall)
    );

    flu_issue_scheduler #(.MulLat(2), .TransIdBits(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .issue_valid_i(valid),
        .issue_fu_i(fu), .issue_trans_id_i(tid), .issue_ready_o(rdy2),
        .alu_valid_o(alu_v2), .branch_valid_o(br_v2), .csr_valid_o(csr_v2),
        .mult_valid_o(mul_v2), .csr_commit_i(commit), .div_done_i(done),
        .exp_wb_valid_o(wb_v2), .exp_wb_trans_id_o(wb_id2), .slot_stall_o(stall2)
    );

    task automatic drive(input logic v, input flu_class_e f, input logic [2:0] id,
                         input logic fl, input logic cm, input logic dd);
        valid = v; fu = f; tid = id; flush = fl; commit = cm; done = dd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(1'b0, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checks++; if (wb_v !== 1'b0 || wb_v2 !== 1'b0) $display("FAIL reset_wb_valid got %0b/%0b want 0/0", wb_v, wb_v2); else passed++;
        checks++; if (wb_id !== 3'd0) $display("FAIL reset_wb_id got %0d want 0", wb_id); else passed++;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, flu_class_e'(3'(i)), 3'd0, 1'b0, 1'b0, 1'b0);
            checks++; if (rdy !== 1'b1 || rdy2 !== 1'b1) $display("FAIL reset_ready class %0d got %0b/%0b want 1/1", i, rdy, rdy2); else passed++;
            checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b0000) $display("FAIL reset_strobes class %0d got %b want 0000", i, {alu_v, br_v, csr_v, mul_v}); else passed++;
        end
    endtask

    task automatic test_alu_grant();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b1) $display("FAIL alu_ready got %0b want 1", rdy); else passed++;
        checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b1000) $display("FAIL alu_strobes got %b want 1000", {alu_v, br_v, csr_v, mul_v}); else passed++;
        tick();
        idle(2);
    endtask

    task automatic test_mul_slot();
        drive(1'b1, MUL, 3'd5, 1'b0, 1'b0, 1'b0);
        checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b0001) $display("FAIL mul_strobes got %b want 0001", {alu_v, br_v, csr_v, mul_v}); else passed++;
        tick();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v !== 1'b1) $display("FAIL mul_wb_valid got %0b want 1", wb_v); else passed++;
        checks++; if (wb_id !== 3'd5) $display("FAIL mul_wb_id got %0d want 5", wb_id); else passed++;
        checks++; if (rdy !== 1'b0 || alu_v !== 1'b0) $display("FAIL mul_alu_blocked got rdy=%0b alu=%0b want 0/0", rdy, alu_v); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL mul_slot_stall got %0b want 1", stall); else passed++;
        tick();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b1 || alu_v !== 1'b1) $display("FAIL mul_alu_resume got rdy=%0b alu=%0b want 1/1", rdy, alu_v); else passed++;
        checks++; if (wb_v !== 1'b0) $display("FAIL mul_wb_drained got %0b want 0", wb_v); else passed++;
        tick();
        idle(3);
    endtask

    task automatic test_csr();
        drive(1'b1, CSR, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b0010) $display("FAIL csr_strobes got %b want 0010", {alu_v, br_v, csr_v, mul_v}); else passed++;
        tick();
        drive(1'b1, CSR, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b0 || stall !== 1'b0) $display("FAIL csr_pending_csr got rdy=%0b stall=%0b want 0/0", rdy, stall); else passed++;
        tick();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b0) $display("FAIL csr_pending_alu got %0b want 0", rdy); else passed++;
        tick();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b1, 1'b0);
        checks++; if (rdy !== 1'b0 || alu_v !== 1'b0) $display("FAIL csr_commit_same_cycle got rdy=%0b alu=%0b want 0/0", rdy, alu_v); else passed++;
        tick();
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b1 || alu_v !== 1'b1) $display("FAIL csr_after_commit got rdy=%0b alu=%0b want 1/1", rdy, alu_v); else passed++;
        tick();
        idle(3);
    endtask

    task automatic test_div();
        int bad;
        drive(1'b1, DIV, 3'd2, 1'b0, 1'b0, 1'b0);
        checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b0001) $display("FAIL div_strobes got %b want 0001", {alu_v, br_v, csr_v, mul_v}); else passed++;
        tick();
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, MUL, 3'd1, 1'b0, 1'b0, 1'b0);
            if (rdy !== 1'b0 || mul_v !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) $display("FAIL div_busy_block got %0d ready cycles want 0", bad); else passed++;
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (rdy !== 1'b0 || stall !== 1'b0) $display("FAIL div_done_cycle got rdy=%0b stall=%0b want 0/0", rdy, stall); else passed++;
        tick();
        drive(1'b1, MUL, 3'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b1 || mul_v !== 1'b1) $display("FAIL div_resume_mul got rdy=%0b mul=%0b want 1/1", rdy, mul_v); else passed++;
        tick();
        idle(3);
        drive(1'b1, ALU, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (rdy !== 1'b0 || stall !== 1'b1) $display("FAIL stray_div_done got rdy=%0b stall=%0b want 0/1", rdy, stall); else passed++;
        tick();
        drive(1'b1, BRANCH, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy !== 1'b1 || br_v !== 1'b1) $display("FAIL stray_div_done_after got rdy=%0b br=%0b want 1/1", rdy, br_v); else passed++;
        tick();
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, MUL, 3'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (rdy !== 1'b1 || mul_v !== 1'b1) $display("FAIL b2b_ready id %0d got rdy=%0b mul=%0b want 1/1", i, rdy, mul_v); else passed++;
            if (i > 1) begin
                checks++; if (wb_v !== 1'b1 || wb_id !== 3'(i - 1)) $display("FAIL b2b_wb cycle %0d got v=%0b id=%0d want 1/%0d", i, wb_v, wb_id, i - 1); else passed++;
            end
            tick();
        end
        drive(1'b0, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v !== 1'b1 || wb_id !== 3'd4) $display("FAIL b2b_last_wb got v=%0b id=%0d want 1/4", wb_v, wb_id); else passed++;
        tick();
        drive(1'b0, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v !== 1'b0) $display("FAIL b2b_drained got %0b want 0", wb_v); else passed++;
        idle(3);
    endtask

    task automatic test_flush();
        drive(1'b1, MUL, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy2 !== 1'b1 || mul_v2 !== 1'b1) $display("FAIL flush_mul1 got rdy=%0b mul=%0b want 1/1", rdy2, mul_v2); else passed++;
        tick();
        drive(1'b1, MUL, 3'd2, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy2 !== 1'b1 || wb_v2 !== 1'b0) $display("FAIL flush_mul2 got rdy=%0b wb=%0b want 1/0", rdy2, wb_v2); else passed++;
        tick();
        drive(1'b1, MUL, 3'd3, 1'b1, 1'b0, 1'b0);
        checks++; if (rdy2 !== 1'b0 || mul_v2 !== 1'b0 || stall2 !== 1'b0) $display("FAIL flush_mul3 got rdy=%0b mul=%0b stall=%0b want 0/0/0", rdy2, mul_v2, stall2); else passed++;
        checks++; if (wb_v2 !== 1'b1 || wb_id2 !== 3'd1) $display("FAIL flush_wb_id1 got v=%0b id=%0d want 1/1", wb_v2, wb_id2); else passed++;
        tick();
        drive(1'b0, DIV, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v2 !== 1'b0) $display("FAIL flush_wb_cleared got %0b want 0", wb_v2); else passed++;
        checks++; if (rdy2 !== 1'b1) $display("FAIL flush_resv_clear got %0b want 1", rdy2); else passed++;
        tick();
        drive(1'b0, ALU, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v2 !== 1'b0) $display("FAIL flush_wb_later got %0b want 0", wb_v2); else passed++;
        idle(3);
    endtask

    task automatic test_illegal();
        for (int f = 5; f <= 7; f++) begin
            drive(1'b1, flu_class_e'(3'(f)), 3'd0, 1'b0, 1'b0, 1'b0);
            checks++; if (rdy !== 1'b0 || stall !== 1'b0) $display("FAIL illegal_%0d got rdy=%0b stall=%0b want 0/0", f, rdy, stall); else passed++;
            checks++; if ({alu_v, br_v, csr_v, mul_v} !== 4'b0000) $display("FAIL illegal_%0d_strobes got %b want 0000", f, {alu_v, br_v, csr_v, mul_v}); else passed++;
            tick();
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, MUL, 3'd7, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, DIV, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (wb_v !== 1'b1 || wb_id !== 3'd7) $display("FAIL rst_mid_before got v=%0b id=%0d want 1/7", wb_v, wb_id); else passed++;
        checks++; if (rdy2 !== 1'b0) $display("FAIL rst_mid_div_blocked got %0b want 0", rdy2); else passed++;
        rst_ni = 1'b0;
        #1;
        checks++; if (wb_v !== 1'b0 || wb_id !== 3'd0) $display("FAIL rst_mid_async got v=%0b id=%0d want 0/0", wb_v, wb_id); else passed++;
        checks++; if (rdy2 !== 1'b1) $display("FAIL rst_mid_resv_clear got %0b want 1", rdy2); else passed++;
        tick();
        rst_ni = 1'b1;
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_grant();
        test_mul_slot();
        test_csr();
        test_div();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
